// File: rtl/int_to_fp16_if.sv
// Beat-level bus for the multi-lane integer to fp16 converter: input beat with
// per-beat mode bits, output beat with per-lane overflow flags.
interface int_to_fp16_if #(
    parameter int IN_W  = 16,
    parameter int LANES = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*IN_W-1:0] in_data;
    logic                  sgn_mode;
    logic                  rnd_mode;
    logic                  sat_en;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*16-1:0]   out_data;
    logic [LANES-1:0]      out_ovf;

    modport master (
        output in_valid, in_data, sgn_mode, rnd_mode, sat_en, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, sgn_mode, rnd_mode, sat_en, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/int_to_fp16_pipe.sv
// Three-stage, multi-lane integer to IEEE-754 half converter with valid/ready
// flow control. Each lane: abs value -> normalise -> round/overflow/pack.
module int_to_fp16_lane #(
    parameter int IN_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld1,
    input  logic            ld2,
    input  logic            ld3,
    input  logic [IN_W-1:0] x,
    input  logic            sgn_mode,
    input  logic            rnd_mode,
    input  logic            sat_en,
    output logic [15:0]     res,
    output logic            ovf
);
    localparam int MW = IN_W + 1;   // one extra bit keeps |most negative|
    localparam int NW = MW + 11;    // padding so guard/sticky always exist
    localparam int PW = 6;

    // S1: sign and magnitude
    logic          neg_c;
    logic [MW-1:0] x_ext, abs_c;
    logic          s1_neg;
    logic [MW-1:0] s1_mag;

    always_comb begin
        neg_c = sgn_mode & x[IN_W-1];
        x_ext = {neg_c, x};
        abs_c = neg_c ? (~x_ext + MW'(1)) : x_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_neg <= 1'b0;
            s1_mag <= '0;
        end else if (ld1) begin
            s1_neg <= neg_c;
            s1_mag <= abs_c;
        end
    end

    // S2: leading-one position and left-justified magnitude
    logic [PW-1:0] p_c;
    logic [MW-1:0] nrm_c;
    logic          s2_neg;
    logic [PW-1:0] s2_p;
    logic [MW-1:0] s2_nrm;

    always_comb begin
        p_c = '0;
        for (int i = 0; i < MW; i++)
            if (s1_mag[i]) p_c = PW'(i);
        nrm_c = s1_mag << (PW'(MW - 1) - p_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_neg <= 1'b0;
            s2_p   <= '0;
            s2_nrm <= '0;
        end else if (ld2) begin
            s2_neg <= s1_neg;
            s2_p   <= p_c;
            s2_nrm <= nrm_c;
        end
    end

    // S3: round, overflow, pack. The normalised MSB doubles as the non-zero flag.
    logic [NW-1:0] ext;
    logic [9:0]    mant;
    logic          g, st, inc, nz, ovf_c;
    logic [10:0]   mr;
    logic [6:0]    e;
    logic [15:0]   res_c;

    always_comb begin
        ext   = {s2_nrm, 11'b0};
        nz    = ext[NW-1];
        mant  = ext[NW-2 -: 10];
        g     = ext[NW-12];
        st    = |ext[NW-13:0];
        inc   = rnd_mode & g & (st | mant[0]);
        mr    = {1'b0, mant} + {10'b0, inc};
        e     = 7'd15 + {1'b0, s2_p} + {6'b0, mr[10]};
        ovf_c = nz & (e >= 7'd31);
        res_c = 16'h0000;
        if (ovf_c)
            res_c = sat_en ? {s2_neg, 15'h7BFF} : {s2_neg, 5'h1F, 10'h000};
        else if (nz)
            res_c = {s2_neg, e[4:0], mr[9:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res <= 16'h0000;
            ovf <= 1'b0;
        end else if (ld3) begin
            res <= res_c;
            ovf <= ovf_c;
        end
    end
endmodule

module int_to_fp16_pipe #(
    parameter int IN_W  = 16,
    parameter int LANES = 4
) (
    input logic           clk,
    input logic           rst_n,
    int_to_fp16_if.slave  bus
);
    localparam int STAGES = 3;

    logic [STAGES:1]        vld_pipe;
    logic                   en1, en2, en3;
    logic                   rnd1, sat1, rnd2, sat2;
    logic [LANES-1:0][15:0] res;
    logic [LANES-1:0]       ovf;

    // a stage may load when it is empty or its contents move on this edge
    assign en3 = ~vld_pipe[3] | bus.out_ready;
    assign en2 = ~vld_pipe[2] | en3;
    assign en1 = ~vld_pipe[1] | en2;

    assign bus.in_ready  = en1;
    assign bus.out_valid = vld_pipe[3];
    assign bus.out_data  = res;
    assign bus.out_ovf   = ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            if (en1) vld_pipe[1] <= bus.in_valid;
            if (en2) vld_pipe[2] <= vld_pipe[1];
            if (en3) vld_pipe[3] <= vld_pipe[2];
        end
    end

    // rounding and saturation modes ride alongside their beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd1 <= 1'b0;
            sat1 <= 1'b0;
            rnd2 <= 1'b0;
            sat2 <= 1'b0;
        end else begin
            if (en1 & bus.in_valid) begin
                rnd1 <= bus.rnd_mode;
                sat1 <= bus.sat_en;
            end
            if (en2 & vld_pipe[1]) begin
                rnd2 <= rnd1;
                sat2 <= sat1;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        int_to_fp16_lane #(.IN_W(IN_W)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .ld1      (en1 & bus.in_valid),
            .ld2      (en2 & vld_pipe[1]),
            .ld3      (en3 & vld_pipe[2]),
            .x        (bus.in_data[g*IN_W +: IN_W]),
            .sgn_mode (bus.sgn_mode),
            .rnd_mode (rnd2),
            .sat_en   (sat2),
            .res      (res[g]),
            .ovf      (ovf[g])
        );
    end
endmodule

// File: tb/tb_int_to_fp16_pipe.sv
// Scoreboard bench: an IN_W=16 and an IN_W=32 instance, directed spec vectors
// plus randomized beats against an arithmetic reference model.
module tb_int_to_fp16_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int_to_fp16_if #(.IN_W(16), .LANES(4)) i16 ();
    int_to_fp16_if #(.IN_W(32), .LANES(4)) i32 ();

    int_to_fp16_pipe #(.IN_W(16), .LANES(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16));
    int_to_fp16_pipe #(.IN_W(32), .LANES(4)) u32 (.clk(clk), .rst_n(rst_n), .bus(i32));

    typedef struct {
        logic [63:0] d;
        logic [3:0]  o;
        int          c;
        bit          lat;
    } exp_t;

    exp_t q16[$];
    exp_t q32[$];
    int total = 0, bad = 0, cyc = 0, or_mode = 0, pcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready: 0 always 1, 1 always 0, 2 pattern 1,0,0, 3 random
    always @(posedge clk) begin
        logic r;
        #1;
        case (or_mode)
            0: r = 1'b1;
            1: r = 1'b0;
            2: r = (pcnt % 3 == 0);
            default: r = 1'($urandom % 2);
        endcase
        pcnt++;
        i16.out_ready = r;
        i32.out_ready = r;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference: real-valued rounding of |x| onto the fp16 grid; returns {ovf, fp16}.
    function automatic logic [16:0] cvt(input logic [63:0] raw_in, input int w,
                                        input bit sg, input bit rn, input bit st);
        longint v, m, q, rem, half;
        int e;
        logic [63:0] raw;
        logic s;
        raw = raw_in & ((64'd1 << w) - 64'd1);
        v = longint'(raw);
        if (sg && raw[w-1]) v = v - (longint'(1) << w);
        s = (v < 0);
        m = s ? -v : v;
        if (m == 0) return 17'd0;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        if (e <= 10) q = m << (10 - e);
        else begin
            q    = m >> (e - 10);
            rem  = m - (q << (e - 10));
            half = longint'(1) << (e - 11);
            if (rn && (rem > half || (rem == half && q[0]))) q++;
            if (q == 2048) begin q = 1024; e++; end
        end
        if (e + 15 >= 31) return {1'b1, s, st ? 15'h7BFF : 15'h7C00};
        return {1'b0, s, 5'(e + 15), 10'(q - 1024)};
    endfunction

    // Call at #1 after a rising edge; returns at #1 after the accepting edge.
    task automatic send(input bit sel, input logic [127:0] d, input bit sg, input bit rn,
                        input bit st, input bit use_exp, input logic [63:0] ed,
                        input logic [3:0] eo);
        exp_t e;
        bit acc = 0;
        int w = sel ? 32 : 16;
        logic [16:0] r;
        if (use_exp) begin
            e.d = ed;
            e.o = eo;
        end else begin
            for (int i = 0; i < 4; i++) begin
                r = cvt(64'(d >> (i * w)), w, sg, rn, st);
                e.d[i*16 +: 16] = r[15:0];
                e.o[i] = r[16];
            end
        end
        e.lat = (or_mode == 0);
        e.c = 0;
        if (sel) begin
            i32.in_valid = 1; i32.in_data = d; i32.sgn_mode = sg; i32.rnd_mode = rn; i32.sat_en = st;
        end else begin
            i16.in_valid = 1; i16.in_data = d[63:0]; i16.sgn_mode = sg; i16.rnd_mode = rn; i16.sat_en = st;
        end
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = sel ? i32.in_ready : i16.in_ready;
            e.c = cyc;
            @(posedge clk);
        end
        if (!acc) begin
            total++; bad++;
            $display("FAIL accept_timeout sel=%0d got=no_accept exp=accept", sel);
        end else if (sel) q32.push_back(e);
        else q16.push_back(e);
        #1;
        if (sel) i32.in_valid = 0; else i16.in_valid = 0;
    endtask

    task automatic send_rand(input bit sel);
        logic [127:0] d = '0;
        logic [31:0] lv;
        for (int i = 0; i < 4; i++) begin
            lv = $urandom >> $urandom_range(0, 31);
            if (sel) d[i*32 +: 32] = lv;
            else d[i*16 +: 16] = lv[15:0];
        end
        send(sel, d, 1'($urandom), 1'($urandom), 1'($urandom), 0, 64'd0, 4'd0);
    endtask

    task automatic drain();
        int k = 0;
        do begin @(posedge clk); k++; end while ((q16.size() != 0 || q32.size() != 0) && k < 300);
        #1;
        if (q16.size() != 0 || q32.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout got=%0d/%0d exp=0/0", q16.size(), q32.size());
        end
    endtask

    task automatic setmode(input int m);
        or_mode = m;
        @(posedge clk); #1;
    endtask

    // Monitors: pop on each output transfer; also check hold-under-stall and in_ready.
    exp_t m16, m32;
    bit st16 = 0, st32 = 0;
    logic [63:0] hd16, hd32;
    logic [3:0]  ho16, ho32;

    always @(negedge clk) begin
        if (!rst_n) st16 = 0;
        else begin
            if (st16) begin
                chk("hold16_valid", 64'(i16.out_valid), 64'd1);
                chk("hold16_data", i16.out_data, hd16);
                chk("hold16_ovf", 64'(i16.out_ovf), 64'(ho16));
            end
            chk("rdy16", 64'(i16.in_ready), 64'(!(q16.size() == 3 && !i16.out_ready)));
            if (i16.out_valid && q16.size() == 0) begin
                total++; bad++;
                $display("FAIL spurious16 got=valid data=%h exp=idle", i16.out_data);
            end else if (i16.out_valid && i16.out_ready) begin
                m16 = q16.pop_front();
                chk("data16", i16.out_data, m16.d);
                chk("ovf16", 64'(i16.out_ovf), 64'(m16.o));
                if (m16.lat) chk("lat16", 64'(cyc - m16.c), 64'd3);
            end
            st16 = i16.out_valid && !i16.out_ready;
            hd16 = i16.out_data;
            ho16 = i16.out_ovf;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) st32 = 0;
        else begin
            if (st32) begin
                chk("hold32_valid", 64'(i32.out_valid), 64'd1);
                chk("hold32_data", i32.out_data, hd32);
                chk("hold32_ovf", 64'(i32.out_ovf), 64'(ho32));
            end
            chk("rdy32", 64'(i32.in_ready), 64'(!(q32.size() == 3 && !i32.out_ready)));
            if (i32.out_valid && q32.size() == 0) begin
                total++; bad++;
                $display("FAIL spurious32 got=valid data=%h exp=idle", i32.out_data);
            end else if (i32.out_valid && i32.out_ready) begin
                m32 = q32.pop_front();
                chk("data32", i32.out_data, m32.d);
                chk("ovf32", 64'(i32.out_ovf), 64'(m32.o));
                if (m32.lat) chk("lat32", 64'(cyc - m32.c), 64'd3);
            end
            st32 = i32.out_valid && !i32.out_ready;
            hd32 = i32.out_data;
            ho32 = i32.out_ovf;
        end
    end

    initial begin
        i16.in_valid = 0; i16.in_data = '0; i16.sgn_mode = 0; i16.rnd_mode = 0; i16.sat_en = 0;
        i32.in_valid = 0; i32.in_data = '0; i32.sgn_mode = 0; i32.rnd_mode = 0; i32.sat_en = 0;
        i16.out_ready = 1; i32.out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst16_valid", 64'(i16.out_valid), 64'd0);
        chk("rst16_data", i16.out_data, 64'd0);
        chk("rst16_ovf", 64'(i16.out_ovf), 64'd0);
        chk("rst32_valid", 64'(i32.out_valid), 64'd0);
        chk("rst32_data", i32.out_data, 64'd0);
        chk("rst32_ovf", 64'(i32.out_ovf), 64'd0);
        rst_n = 1;
        #1;
        chk("rst16_ready", 64'(i16.in_ready), 64'd1);
        chk("rst32_ready", 64'(i32.in_ready), 64'd1);
        @(posedge clk); #1;

        // directed vectors, lane 0 in the low bits
        send(0, {64'd0, 16'h8000, 16'h0000, 16'hFFFF, 16'h0001}, 1, 1, 0, 1,
             {16'hF800, 16'h0000, 16'hBC00, 16'h3C00}, 4'b0000);
        send(0, {64'd0, 16'hFFFF, 16'h7FFF, 16'h0803, 16'h0801}, 0, 1, 0, 1,
             {16'h7C00, 16'h7800, 16'h6802, 16'h6800}, 4'b1000);
        send(0, {64'd0, 16'hFFFF, 16'h7FFF, 16'h0803, 16'h0801}, 0, 0, 0, 1,
             {16'h7BFF, 16'h77FF, 16'h6801, 16'h6800}, 4'b0000);
        send(0, {64'd0, 16'h7FFF, 16'h0803, 16'h0801, 16'hFFFF}, 1, 1, 0, 1,
             {16'h7800, 16'h6802, 16'h6800, 16'hBC00}, 4'b0000);
        send(1, {32'd1, 32'd0, 32'd65520, 32'd65519}, 0, 1, 0, 1,
             {16'h3C00, 16'h0000, 16'h7C00, 16'h7BFF}, 4'b0010);
        send(1, {32'hFFFFFFFF, 32'd70000, 32'd65519, 32'd65520}, 0, 1, 1, 1,
             {16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h7BFF}, 4'b1101);
        send(1, {32'd1, 32'd65519, 32'd65520, 32'd70000}, 0, 0, 0, 1,
             {16'h3C00, 16'h7BFF, 16'h7BFF, 16'h7C00}, 4'b0001);
        send(1, {32'd0, 32'd3, 32'hFFFFFFFF, 32'h80000000}, 1, 1, 0, 1,
             {16'h0000, 16'h4200, 16'hBC00, 16'hFC00}, 4'b0001);
        drain();

        // backpressure 1,0,0 with 8 distinct beats
        setmode(2);
        for (int i = 0; i < 8; i++) send_rand(0);
        drain();

        // random traffic with random backpressure and input gaps
        setmode(3);
        for (int i = 0; i < 80; i++) begin
            send_rand(1'(i % 2));
            if ($urandom % 4 == 0) begin @(posedge clk); #1; end
        end
        drain();

        // stall-free random beats with latency checking
        setmode(0);
        for (int i = 0; i < 20; i++) send_rand(1'(i % 2));
        drain();

        // reset with a full pipeline
        setmode(1);
        for (int i = 0; i < 3; i++) send_rand(0);
        chk("full16_ready", 64'(i16.in_ready), 64'd0);
        rst_n = 0;
        #1;
        chk("midrst16_valid", 64'(i16.out_valid), 64'd0);
        q16.delete();
        q32.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        setmode(0);
        repeat (6) @(posedge clk);
        #1;
        send(0, {64'd0, 16'h8000, 16'h0000, 16'hFFFF, 16'h0001}, 1, 1, 0, 1,
             {16'hF800, 16'h0000, 16'hBC00, 16'h3C00}, 4'b0000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
